// File: rtl/carry_resolve_pkg.sv
// Shared widths and FSM encoding for the carry-save resolver.
// The inner-loop stage and outer controller take W from here as well.
package carry_resolve_pkg;

    localparam int W      = 3128;
    localparam int CHUNK  = 136;
    localparam int NCHUNK = W / CHUNK;
    localparam int CNT_W  = $clog2(NCHUNK);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/carry_resolve_chunk_adder.sv
// Combinational N-bit unsigned adder with carry-in and carry-out.
module chunk_adder
    import carry_resolve_pkg::*;
#(
    parameter int N = CHUNK
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/carry_resolve.sv
// Serial carry-propagate resolver: adds a captured carry-save pair one
// CHUNK per cycle and publishes the sum with a one-cycle en_out pulse.
module carry_resolve
    import carry_resolve_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] r0,
    input  logic [W-1:0] r1,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy,
    output logic         en_out
);

    generate
        if ((W % CHUNK) != 0) begin : g_bad_chunk
            $error("carry_resolve: W must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic [W-1:0]     op0_r;
    logic [W-1:0]     op1_r;
    logic [W-1:0]     acc_r;
    logic [W-1:0]     sum_r;
    logic             cout_r;
    logic             en_out_r;

    logic [CHUNK-1:0] chunk_sum_s;
    logic             chunk_cout_s;
    logic [W-1:0]     acc_next_s;

    chunk_adder #(.N(CHUNK)) u_chunk_adder (
        .a    (op0_r[CHUNK-1:0]),
        .b    (op1_r[CHUNK-1:0]),
        .cin  (carry_r),
        .s    (chunk_sum_s),
        .cout (chunk_cout_s)
    );

    // Newest chunk enters at the top so the LSB chunk lands at bit 0 last.
    assign acc_next_s = {chunk_sum_s, acc_r[W-1:CHUNK]};
    assign busy       = (state_r == RUN);

    // Resolver FSM, operand/accumulator shifters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            carry_r  <= 1'b0;
            op0_r    <= '0;
            op1_r    <= '0;
            acc_r    <= '0;
            sum_r    <= '0;
            cout_r   <= 1'b0;
            en_out_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    en_out_r <= 1'b0;
                    if (en) begin
                        op0_r   <= r0;
                        op1_r   <= r1;
                        carry_r <= 1'b0;
                        cnt_r   <= '0;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    op0_r   <= op0_r >> CHUNK;
                    op1_r   <= op1_r >> CHUNK;
                    acc_r   <= acc_next_s;
                    carry_r <= chunk_cout_s;
                    if (cnt_r == CNT_W'(NCHUNK - 1)) begin
                        sum_r    <= acc_next_s;
                        cout_r   <= chunk_cout_s;
                        en_out_r <= 1'b1;
                        cnt_r    <= '0;
                        state_r  <= IDLE;
                    end else begin
                        en_out_r <= 1'b0;
                        cnt_r    <= cnt_r + CNT_W'(1);
                        state_r  <= RUN;
                    end
                end
                default: begin
                    en_out_r <= 1'b0;
                    cnt_r    <= '0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign sum    = sum_r;
    assign cout   = cout_r;
    assign en_out = en_out_r;

endmodule

// File: tb/tb_carry_resolve.sv
// Directed and table-driven bench for carry_resolve: latency, busy window,
// result hold, ignored strobes and mid-run reset.
module tb_carry_resolve;
    import carry_resolve_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] r0;
    logic [W-1:0] r1;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         en_out;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] held_sum  = '0;
    logic         held_cout = 1'b0;

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t vecs[5];

    carry_resolve dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .r0     (r0),
        .r1     (r1),
        .sum    (sum),
        .cout   (cout),
        .busy   (busy),
        .en_out (en_out)
    );

    always #5 clk = ~clk;

    task automatic chk_w(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        int first_diff;
        checks++;
        if (act !== exp) begin
            failures++;
            first_diff = -1;
            for (int i = W - 1; i >= 0; i--) begin
                if (act[i] !== exp[i]) first_diff = i;
            end
            $display("FAIL %s: actual[63:0]=%h required[63:0]=%h first_diff_bit=%0d",
                     nm, act[63:0], exp[63:0], first_diff);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < W; i += 32) v = {v[W-33:0], 32'($urandom())};
        return v;
    endfunction

    // Full capture-to-result window; the next call's capture lands on E24.
    task automatic resolve(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_s, input logic exp_c);
        int bad_busy, bad_pulse, bad_hold;
        bad_busy = 0; bad_pulse = 0; bad_hold = 0;
        @(negedge clk); r0 = a; r1 = b; en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (busy !== 1'b1) bad_busy++;
            if (en_out !== 1'b0) bad_pulse++;
            if (sum !== held_sum || cout !== held_cout) bad_hold++;
            @(posedge clk); #1;
        end
        chk_i({nm, " busy_gaps_E0_E22"}, bad_busy, 0);
        chk_i({nm, " early_en_out"}, bad_pulse, 0);
        chk_i({nm, " sum_hold_during_run"}, bad_hold, 0);
        chk_i({nm, " en_out_at_E23"}, int'(en_out), 1);
        chk_i({nm, " busy_after_E23"}, int'(busy), 0);
        chk_w({nm, " sum"}, sum, exp_s);
        chk_i({nm, " cout"}, int'(cout), int'(exp_c));
        held_sum  = exp_s;
        held_cout = exp_c;
    endtask

    task automatic count_idle(input string nm, input int n);
        int pulses, busys;
        pulses = 0; busys = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (en_out !== 1'b0) pulses++;
            if (busy !== 1'b0) busys++;
        end
        chk_i({nm, " stray_en_out"}, pulses, 0);
        chk_i({nm, " stray_busy"}, busys, 0);
    endtask

    initial begin
        logic [W-1:0] a, b;
        logic [W:0]   full;

        vecs[0] = '{"zeros", '0, '0, '0, 1'b0};
        vecs[1] = '{"ones_plus_one", {W{1'b1}}, {{(W-1){1'b0}}, 1'b1}, '0, 1'b1};
        vecs[2] = '{"half_plus_halfm1", {1'b1, {(W-1){1'b0}}}, {1'b0, {(W-1){1'b1}}},
                    {W{1'b1}}, 1'b0};
        vecs[3] = '{"chunk0_carry", {{(W-CHUNK){1'b0}}, {CHUNK{1'b1}}},
                    {{(W-1){1'b0}}, 1'b1},
                    {{(W-CHUNK-1){1'b0}}, 1'b1, {CHUNK{1'b0}}}, 1'b0};
        vecs[4] = '{"ones_plus_ones", {W{1'b1}}, {W{1'b1}}, {{(W-1){1'b1}}, 1'b0}, 1'b1};

        rst_n = 1'b0; en = 1'b0; r0 = '0; r1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_w("reset sum", sum, '0);
        chk_i("reset cout", int'(cout), 0);
        chk_i("reset busy", int'(busy), 0);
        chk_i("reset en_out", int'(en_out), 0);
        @(negedge clk); rst_n = 1'b1;
        count_idle("post_reset_idle", 3);

        foreach (vecs[i]) resolve(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c);

        for (int n = 0; n < 200; n++) begin
            a = rand_w();
            b = rand_w();
            full = {1'b0, a} + {1'b0, b};
            resolve($sformatf("rand%0d", n), a, b, full[W-1:0], full[W]);
        end
        count_idle("after_random", 2);

        // Strobes at E5 and E23 must not disturb or restart the resolve.
        a = rand_w(); b = rand_w();
        full = {1'b0, a} + {1'b0, b};
        @(negedge clk); r0 = a; r1 = b; en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); r0 = ~a; r1 = ~b; en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
        chk_i("strobe busy_after_E5", int'(busy), 1);
        repeat (17) @(posedge clk);
        @(negedge clk); r0 = b; r1 = b; en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
        chk_i("strobe en_out_at_E23", int'(en_out), 1);
        chk_w("strobe sum_first_operands", sum, full[W-1:0]);
        chk_i("strobe cout_first_operands", int'(cout), int'(full[W]));
        held_sum = full[W-1:0]; held_cout = full[W];
        count_idle("strobe_E23_ignored", 30);
        chk_w("strobe sum_held", sum, held_sum);

        // Asynchronous reset just before E10 discards the run and prior result.
        a = rand_w(); b = rand_w();
        @(negedge clk); r0 = a; r1 = b; en = 1'b1;
        @(posedge clk); #1; en = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk_w("midrst sum", sum, '0);
        chk_i("midrst cout", int'(cout), 0);
        chk_i("midrst busy", int'(busy), 0);
        chk_i("midrst en_out", int'(en_out), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        held_sum = '0; held_cout = 1'b0;
        count_idle("midrst_no_pulse", 30);
        a = rand_w(); b = rand_w();
        full = {1'b0, a} + {1'b0, b};
        resolve("after_midrst", a, b, full[W-1:0], full[W]);
        count_idle("final_idle", 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
